aes_block_source: RTL

AES_BLOCK_SOURCE -- requirements
Module: aes_block_source

---
 rtl/aes_block_source.sv | 103 ++++++++++
 1 files changed

// File: rtl/aes_block_source.sv
// Block source: accepts a 128-bit plaintext block plus AES-128 key and streams
// both out as four 32-bit words each over independent valid/ready channels.
module aes_block_source #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 blk_valid_i,
    output logic                 blk_ready_o,
    input  logic [127:0]         blk_data_i,
    input  logic [127:0]         blk_key_i,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic [31:0]          word_data_o,
    output logic [3:0]           word_strb_o,
    output logic                 key_valid_o,
    input  logic                 key_ready_i,
    output logic [31:0]          key_data_o,
    output logic [3:0]           key_strb_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] blk_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state;
    logic [127:0]         data_q;
    logic [127:0]         key_q;
    logic [2:0]           word_idx;
    logic [2:0]           key_idx;
    logic [CNT_WIDTH-1:0] cnt;

    // Word 0 sits in the top 32 bits; index 4 means the stream is exhausted.
    function automatic logic [31:0] pick_word(input logic [127:0] v, input logic [1:0] i);
        case (i)
            2'd0:    pick_word = v[127:96];
            2'd1:    pick_word = v[95:64];
            2'd2:    pick_word = v[63:32];
            default: pick_word = v[31:0];
        endcase
    endfunction

    logic word_fire;
    logic key_fire;

    always_comb begin
        blk_ready_o  = (state == IDLE);
        busy_o       = (state == SEND);
        word_valid_o = (state == SEND) && (word_idx < 3'd4);
        key_valid_o  = (state == SEND) && (key_idx < 3'd4);
        word_data_o  = pick_word(data_q, word_idx[1:0]);
        key_data_o   = pick_word(key_q, key_idx[1:0]);
        word_strb_o  = 4'hF;
        key_strb_o   = 4'hF;
        blk_cnt_o    = cnt;
        word_fire    = word_valid_o && word_ready_i;
        key_fire     = key_valid_o && key_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            data_q   <= '0;
            key_q    <= '0;
            word_idx <= '0;
            key_idx  <= '0;
            cnt      <= '0;
        end else if (clear_i) begin
            // Soft clear drops the block in flight but keeps the completed count.
            state    <= IDLE;
            data_q   <= '0;
            key_q    <= '0;
            word_idx <= '0;
            key_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid_i) begin
                        data_q   <= blk_data_i;
                        key_q    <= blk_key_i;
                        word_idx <= '0;
                        key_idx  <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (word_fire) word_idx <= word_idx + 3'd1;
                    if (key_fire)  key_idx  <= key_idx + 3'd1;
                    if (word_idx == 3'd4 && key_idx == 3'd4) begin
                        state <= IDLE;
                        cnt   <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
